mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the multi-cycle CPU memory port and a secondary master (DMA/debug loader). It accepts one request at a time and sequences a fixed-latency memory access. It returns read data with a one-cycle acknowledge pulse to the requester that owned the access. It sits between the CPU's memory-address mux (PC/ALUOut via IorD) and the memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory access cycles (legal range ≥1); read data sampled on last access cycle
---
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- c_req  in  1  CPU request; address, write enable and write data held stable while high
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_rdata  out  DW  CPU read data register; valid from c_ack onward
- c_ack  out  1  CPU completion, one-cycle pulse
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack: same as the c_* ports, for the secondary master
- mem_en  out  1  memory enable, high for all access cycles
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  latched access address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in ACCESS and DONE
- owner  out  1  0 = CPU, 1 = secondary; meaningful while busy

## Operation
- States: IDLE, ACCESS, DONE. A down-counter of width clog2(LAT+1) runs in ACCESS.
- **IDLE:**
  - If any request is high, the arbiter picks a winner and latches its we/addr/wdata and owner.
  - Counter loads LAT-1; next state is ACCESS.
  - With no request, it stays in IDLE.
- **ACCESS:**
  - mem_en is 1; mem_addr and mem_wdata come from the latches.
  - mem_we equals the latched we in the first ACCESS cycle only, so there is exactly one write strobe per access.
  - The counter decrements each cycle.
  - When the counter reaches 0:
    - For a read, mem_rdata is captured into the owner's rdata register.
    - For a write, rdata is unchanged.
    - Next state is DONE.
- **DONE:**
  - The owner's ack is 1 for this cycle only.
  - Next state is IDLE unconditionally.
- **Arbitration:** the arbiter decides only in IDLE and never pre-empts an access in progress.
  - Without the configuration macro, priority is fixed: CPU wins ties.
- **Request dropped mid-access:** the access still completes and ack still pulses. The requester must ignore an unexpected ack.
- **Address change mid-access:** has no effect, because all memory-side signals come from the latches.
- **Reset values:** all outputs are 0, including c_rdata, d_rdata and owner. State is IDLE and the counter is 0.
- **Reset asserted mid-access:** takes effect immediately and asynchronously. No ack is issued, and the aborted access is not retried.

## Timing
- A request first seen high in IDLE at cycle 0 gives:
  - ACCESS in cycles 1..LAT
  - ack and valid rdata in cycle LAT+1
  - IDLE in cycle LAT+2
- Throughput is one access per LAT+2 cycles.
- The earliest following grant is sampled in cycle LAT+2. A requester that keeps req high after its ack is treated as a new request.
- mem_rdata is sampled at the rising edge that ends ACCESS cycle LAT.
- mem_en falls in the DONE cycle.
- c_ack and d_ack are never high in the same cycle.

## Configuration
- **Macro:** MEM_ARB_RR_EN.
- **Defined:** round-robin arbitration.
  - A last-owner register resets to 1 (secondary), so the first tie goes to the CPU.
  - On a tie, the port not served last wins. A single requester always wins.
  - last_owner updates on each IDLE→ACCESS transition.
- **Undefined:** fixed CPU priority and no last-owner register. A CPU holding c_req continuously starves the secondary port.

## Test plan
- CPU read, LAT=2, memory[0x40]=0x00001234, c_req at cycle 0 → mem_en in cycles 1-2, mem_we=0, c_ack only in cycle 3, c_rdata=0x00001234, busy low from cycle 4.
- Secondary write, d_addr=0x80, d_wdata=0xDEADBEEF → mem_we high exactly one cycle (cycle 1), d_ack in cycle 3; CPU read of 0x80 then returns 0xDEADBEEF.
- Both requests at cycle 0, CPU drops c_req after its ack, LAT=2 → c_ack in cycle 3, secondary ACCESS in cycles 5-6, d_ack in cycle 7, owner=1 during cycles 5-7.
- Both requests held high for 4 accesses → with MEM_ARB_RR_EN, owners are C,D,C,D; without it, owners are C,C,C,C and d_ack never pulses.
- rst pulsed during ACCESS cycle 1 of a CPU write → all outputs 0 immediately, no c_ack, memory content is the pre-write value if rst hits before the strobe edge; a fresh request afterwards completes normally.
- CPU drops c_req in cycle 1 of a read → access completes, c_ack in cycle 3 with the read data, no second access issued.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus memory macro view.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic [DW-1:0] c_rdata;
   logic          c_ack;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;
   logic          owner;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_wdata,
      input  mem_rdata,
      output c_rdata, c_ack, d_rdata, d_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, owner
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_wdata,
      output mem_rdata,
      input  c_rdata, c_ack, d_rdata, d_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/secondary memory arbiter: one access per LAT+2 cycles, ack pulse in cycle LAT+1, no pre-emption.
// Ties go to the CPU unless MEM_ARB_RR_EN is defined, which selects round-robin.
module mem_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int            CW       = $clog2(LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          owner_q, owner_d;
   logic [DW-1:0] c_rdata_q, c_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          sel_sec;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   // On a tie the port that was not served last wins.
   assign sel_sec = bus.d_req & (~bus.c_req | ~last_q);
`else
   assign sel_sec = bus.d_req & ~bus.c_req;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      owner_d   = owner_q;
      c_rdata_d = c_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_d    = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.c_req || bus.d_req) begin
               owner_d = sel_sec;
               we_d    = sel_sec ? bus.d_we    : bus.c_we;
               addr_d  = sel_sec ? bus.d_addr  : bus.c_addr;
               wdata_d = sel_sec ? bus.d_wdata : bus.c_wdata;
               cnt_d   = CNT_INIT;
               state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
               last_d  = sel_sec;
`endif
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  if (owner_q) d_rdata_d = bus.mem_rdata;
                  else         c_rdata_d = bus.mem_rdata;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         owner_q   <= 1'b0;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         owner_q   <= owner_d;
         c_rdata_q <= c_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   // Counter sits at LAT-1 only in the first ACCESS cycle, giving a single write strobe.
   assign bus.mem_en    = (state_q == ACCESS);
   assign bus.mem_we    = (state_q == ACCESS) && we_q && (cnt_q == CNT_INIT);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.c_rdata   = c_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.c_ack     = (state_q == DONE) && !owner_q;
   assign bus.d_ack     = (state_q == DONE) && owner_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.owner     = owner_q;
endmodule
